// File: rtl/rgb565_to_gray_stream_if.sv
// Pixel stream bundle for the RGB565 -> luma converter: RGB input side and
// gray output side with frame position sidebands.
interface rgb565_to_gray_stream_if #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned W          = 8
);
    localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic          rgb_valid;
    logic          rgb_ready;
    logic [15:0]   rgb_data;
    logic          y_valid;
    logic          y_ready;
    logic [W-1:0]  y_data;
    logic          y_last;
    logic          frame_done;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Converter side: consumes RGB pixels, produces gray pixels.
    modport slave (
        input  rgb_valid, rgb_data, y_ready,
        output rgb_ready, y_valid, y_data, y_last, frame_done, col, row
    );

    // Environment side: drives RGB pixels, consumes gray pixels.
    modport master (
        output rgb_valid, rgb_data, y_ready,
        input  rgb_ready, y_valid, y_data, y_last, frame_done, col, row
    );
endinterface

// File: rtl/rgb565_to_gray_stream.sv
// RGB565 to 8-bit luma converter: 2-stage valid/ready pipeline with full
// backpressure and output-side row/column tracking with end-of-frame flags.
module rgb565_to_gray_stream #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned W          = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    rgb565_to_gray_stream_if.slave bus
);
    localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

    // The luma datapath is hard-wired to 8 bits.
    if (W != 8) begin : g_bad_width
        $error("rgb565_to_gray_stream: W must be 8");
    end

    logic          s1_valid;
    logic [15:0]   pr_q;
    logic [15:0]   pg_q;
    logic [15:0]   pb_q;
    logic          s2_valid;
    logic [W-1:0]  y_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          frame_done_q;

    logic          s1_load;
    logic          s2_load;
    logic          out_xfer;
    logic          at_last;
    logic [7:0]    r8;
    logic [7:0]    g8;
    logic [7:0]    b8;
    logic [15:0]   luma_sum;

    // Channel expansion, handshake qualifiers and luma sum.
    always_comb begin
        r8       = {bus.rgb_data[15:11], bus.rgb_data[15:13]};
        g8       = {bus.rgb_data[10:5],  bus.rgb_data[10:9]};
        b8       = {bus.rgb_data[4:0],   bus.rgb_data[4:2]};
        // Coefficients sum to 256, so the 16-bit sum cannot overflow.
        luma_sum = pr_q + pg_q + pb_q;
        s2_load  = !s2_valid || bus.y_ready;
        s1_load  = !s1_valid || s2_load;
        out_xfer = s2_valid && bus.y_ready;
        at_last  = (col_q == COL_MAX) && (row_q == ROW_MAX);
    end

    // Stage 1: weighted channel products.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            pr_q     <= 16'd0;
            pg_q     <= 16'd0;
            pb_q     <= 16'd0;
        end else if (s1_load) begin
            s1_valid <= bus.rgb_valid;
            if (bus.rgb_valid) begin
                pr_q <= 16'(r8) * 16'd77;
                pg_q <= 16'(g8) * 16'd150;
                pb_q <= 16'(b8) * 16'd29;
            end
        end
    end

    // Stage 2: truncated luma output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y_q      <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y_q <= W'(luma_sum[15:8]);
            end
        end
    end

    // Output pixel position, advancing on each output transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (out_xfer) begin
            if (col_q == COL_MAX) begin
                col_q <= '0;
                row_q <= (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // One-cycle pulse after the final pixel of a frame leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= out_xfer && at_last;
        end
    end

    assign bus.rgb_ready  = s1_load;
    assign bus.y_valid    = s2_valid;
    assign bus.y_data     = y_q;
    assign bus.y_last     = s2_valid && at_last;
    assign bus.frame_done = frame_done_q;
    assign bus.col        = col_q;
    assign bus.row        = row_q;
endmodule

// File: tb/tb_rgb565_to_gray_stream.sv
// Self-checking bench for rgb565_to_gray_stream on a 4x3 frame geometry.
module tb_rgb565_to_gray_stream;
    localparam int unsigned IW  = 4;
    localparam int unsigned IH  = 3;
    localparam int unsigned PIX = IW * IH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rgb565_to_gray_stream_if #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8)) bus ();

    rgb565_to_gray_stream #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: pending expected luma values and output pixel count.
    int   exp_q[$];
    int   out_idx = 0;
    logic exp_fd = 1'b0;

    // Observations of the cycle just executed by drive().
    logic       in_fire, out_fire, obs_yvalid, obs_rdy, obs_last, obs_fd;
    logic [7:0] obs_data;
    logic [1:0] obs_col, obs_row;
    int         exp_data, exp_col, exp_row;
    logic       exp_last, exp_fd_now;

    // Luma from plain integer arithmetic on the channel fields.
    function automatic int gray(input logic [15:0] p);
        int r, g, b, r8, g8, b8;
        r  = int'(p[15:11]);
        g  = int'(p[10:5]);
        b  = int'(p[4:0]);
        r8 = r * 8 + r / 4;
        g8 = g * 4 + g / 16;
        b8 = b * 8 + b / 4;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    // Apply inputs for one cycle, record what happens, update the model.
    task automatic drive(input logic v, input logic [15:0] d, input logic yr);
        bus.rgb_valid = v;
        bus.rgb_data  = d;
        bus.y_ready   = yr;
        #2;
        obs_yvalid = bus.y_valid;
        obs_rdy    = bus.rgb_ready;
        obs_last   = bus.y_last;
        obs_fd     = bus.frame_done;
        obs_data   = bus.y_data;
        obs_col    = bus.col;
        obs_row    = bus.row;
        in_fire    = v && obs_rdy;
        out_fire   = obs_yvalid && yr;
        exp_col    = int'(out_idx % IW);
        exp_row    = int'((out_idx / IW) % IH);
        exp_last   = ((out_idx % PIX) == PIX - 1);
        exp_fd_now = exp_fd;
        exp_data   = -1;
        if (out_fire && exp_q.size() > 0) exp_data = exp_q.pop_front();
        if (in_fire) exp_q.push_back(gray(d));
        exp_fd = out_fire && exp_last;
        if (out_fire) out_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n         = 1'b0;
        bus.rgb_valid = 1'b0;
        bus.rgb_data  = 16'h0;
        bus.y_ready   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_q.delete();
        out_idx = 0;
        exp_fd  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++; if (bus.y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid got=%0b exp=0", bus.y_valid); end
        checks++; if (bus.y_data !== 8'd0) begin failures++; $display("FAIL reset_y_data got=%0d exp=0", bus.y_data); end
        checks++; if (bus.y_last !== 1'b0) begin failures++; $display("FAIL reset_y_last got=%0b exp=0", bus.y_last); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", bus.frame_done); end
        checks++; if (bus.col !== 2'd0 || bus.row !== 2'd0) begin failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(0,0)", bus.col, bus.row); end
        checks++; if (bus.rgb_ready !== 1'b1) begin failures++; $display("FAIL reset_rgb_ready got=%0b exp=1", bus.rgb_ready); end
    endtask

    task automatic test_basic();
        logic [15:0] pix [5];
        int          tbl [5];
        int          n;
        pix = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};
        tbl = '{255, 0, 76, 149, 28};
        n = 0;
        for (int k = 0; k < 10; k++) begin
            drive(k < 5, (k < 5) ? pix[k] : 16'h0, 1'b1);
            checks++; if (in_fire !== (k < 5)) begin failures++; $display("FAIL basic_accept k=%0d got=%0b exp=%0b", k, in_fire, (k < 5)); end
            checks++; if (out_fire !== (k >= 2 && k < 7)) begin failures++; $display("FAIL basic_timing k=%0d got=%0b exp=%0b", k, out_fire, (k >= 2 && k < 7)); end
            if (out_fire && n < 5) begin
                checks++; if (int'(obs_data) !== tbl[n]) begin failures++; $display("FAIL basic_data n=%0d got=%0d exp=%0d", n, obs_data, tbl[n]); end
                checks++; if (int'(obs_col) !== exp_col || int'(obs_row) !== exp_row) begin failures++; $display("FAIL basic_pos n=%0d got=(%0d,%0d) exp=(%0d,%0d)", n, obs_col, obs_row, exp_col, exp_row); end
                n++;
            end
        end
        checks++; if (n !== 5) begin failures++; $display("FAIL basic_count got=%0d exp=5", n); end
    endtask

    task automatic test_backpressure();
        logic [15:0] p [4];
        logic [7:0]  held;
        logic        have;
        int          idx, n;
        for (int i = 0; i < 4; i++) p[i] = 16'($urandom);
        idx = 0; n = 0; have = 1'b0; held = 8'd0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, p[idx], 1'b0);
            if (in_fire) idx++;
            if (obs_yvalid && !have) begin have = 1'b1; held = obs_data; end
            else if (obs_yvalid) begin
                checks++; if (obs_data !== held) begin failures++; $display("FAIL stall_stable got=%0d exp=%0d", obs_data, held); end
            end
        end
        checks++; if (idx !== 2) begin failures++; $display("FAIL stall_accepted got=%0d exp=2", idx); end
        checks++; if (obs_rdy !== 1'b0) begin failures++; $display("FAIL stall_rgb_ready got=%0b exp=0", obs_rdy); end
        for (int c = 0; c < 40 && n < 4; c++) begin
            drive(idx < 4, p[idx < 4 ? idx : 0], 1'b1);
            if (in_fire) idx++;
            if (out_fire) begin
                checks++; if (int'(obs_data) !== exp_data) begin failures++; $display("FAIL stall_drain_data n=%0d got=%0d exp=%0d", n, obs_data, exp_data); end
                n++;
            end
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 16'h0, 1'b1);
            if (out_fire) n++;
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL stall_out_count got=%0d exp=4", n); end
    endtask

    task automatic test_random();
        int   sent;
        logic v, yr;
        do_reset(1);
        sent = 0;
        for (int c = 0; c < 60000 && (sent < 10000 || exp_q.size() > 0); c++) begin
            v  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            yr = ($urandom_range(0, 3) != 0);
            drive(v, 16'($urandom), yr);
            if (in_fire) sent++;
            checks++; if (obs_fd !== exp_fd_now) begin failures++; $display("FAIL rand_frame_done got=%0b exp=%0b", obs_fd, exp_fd_now); end
            checks++; if (obs_last !== (obs_yvalid && exp_last)) begin failures++; $display("FAIL rand_y_last got=%0b exp=%0b", obs_last, (obs_yvalid && exp_last)); end
            if (out_fire) begin
                checks++; if (int'(obs_data) !== exp_data) begin failures++; $display("FAIL rand_data got=%0d exp=%0d", obs_data, exp_data); end
                checks++; if (int'(obs_col) !== exp_col || int'(obs_row) !== exp_row) begin failures++; $display("FAIL rand_pos got=(%0d,%0d) exp=(%0d,%0d)", obs_col, obs_row, exp_col, exp_row); end
            end
        end
        checks++; if (sent !== 10000 || exp_q.size() !== 0) begin failures++; $display("FAIL rand_complete got=%0d/%0d exp=10000/0", sent, exp_q.size()); end
    endtask

    task automatic test_frames();
        int sent, n, lasts, fds;
        do_reset(1);
        sent = 0; n = 0; lasts = 0; fds = 0;
        for (int c = 0; c < 60 && n < 24; c++) begin
            drive(sent < 24, 16'($urandom), 1'b1);
            if (in_fire) sent++;
            if (obs_fd) fds++;
            if (out_fire) begin
                checks++; if (int'(obs_col) !== n % 4 || int'(obs_row) !== (n / 4) % 3) begin failures++; $display("FAIL frame_pos n=%0d got=(%0d,%0d) exp=(%0d,%0d)", n, obs_col, obs_row, n % 4, (n / 4) % 3); end
                checks++; if (int'(obs_data) !== exp_data) begin failures++; $display("FAIL frame_data n=%0d got=%0d exp=%0d", n, obs_data, exp_data); end
                if (obs_last) begin
                    lasts++;
                    checks++; if (n + 1 != 12 && n + 1 != 24) begin failures++; $display("FAIL frame_last_pos got=%0d exp=12or24", n + 1); end
                end
                n++;
            end
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 16'h0, 1'b1);
            if (obs_fd) fds++;
        end
        checks++; if (n !== 24) begin failures++; $display("FAIL frame_count got=%0d exp=24", n); end
        checks++; if (lasts !== 2) begin failures++; $display("FAIL frame_lasts got=%0d exp=2", lasts); end
        checks++; if (fds !== 2) begin failures++; $display("FAIL frame_done_pulses got=%0d exp=2", fds); end
    endtask

    task automatic test_mid_reset();
        logic [15:0] pix [3];
        int          tbl [3];
        int          outs, sent;
        pix = '{16'h07E0, 16'h001F, 16'hFFFF};
        tbl = '{149, 28, 255};
        do_reset(1);
        outs = 0;
        for (int c = 0; c < 40 && outs < 5; c++) begin
            drive(1'b1, 16'($urandom), 1'b1);
            if (out_fire) outs++;
        end
        checks++; if (bus.y_valid !== 1'b1) begin failures++; $display("FAIL midrst_prefull got=%0b exp=1", bus.y_valid); end
        do_reset(1);
        checks++; if (bus.y_valid !== 1'b0) begin failures++; $display("FAIL midrst_y_valid got=%0b exp=0", bus.y_valid); end
        checks++; if (bus.col !== 2'd0 || bus.row !== 2'd0) begin failures++; $display("FAIL midrst_pos got=(%0d,%0d) exp=(0,0)", bus.col, bus.row); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL midrst_frame_done got=%0b exp=0", bus.frame_done); end
        outs = 0; sent = 0;
        for (int c = 0; c < 20; c++) begin
            drive(sent < 3, pix[sent < 3 ? sent : 0], 1'b1);
            if (in_fire) sent++;
            if (out_fire) begin
                if (outs < 3) begin
                    checks++; if (int'(obs_data) !== tbl[outs]) begin failures++; $display("FAIL midrst_data n=%0d got=%0d exp=%0d", outs, obs_data, tbl[outs]); end
                    checks++; if (int'(obs_col) !== outs || obs_row !== 2'd0) begin failures++; $display("FAIL midrst_newpos n=%0d got=(%0d,%0d) exp=(%0d,0)", outs, obs_col, obs_row, outs); end
                end
                outs++;
            end
        end
        checks++; if (outs !== 3) begin failures++; $display("FAIL midrst_out_count got=%0d exp=3", outs); end
    endtask

    task automatic test_last_stall();
        int   sent, stall;
        logic yr;
        do_reset(1);
        sent = 0; stall = 0;
        for (int c = 0; c < 60 && stall < 4; c++) begin
            yr = (out_idx != 11);
            drive(sent < 12, 16'($urandom), yr);
            if (in_fire) sent++;
            if (!yr && obs_yvalid) begin
                stall++;
                checks++; if (obs_last !== 1'b1) begin failures++; $display("FAIL last_stall_y_last got=%0b exp=1", obs_last); end
                checks++; if (obs_fd !== 1'b0) begin failures++; $display("FAIL last_stall_frame_done got=%0b exp=0", obs_fd); end
            end
        end
        checks++; if (stall !== 4) begin failures++; $display("FAIL last_stall_reached got=%0d exp=4", stall); end
        drive(1'b0, 16'h0, 1'b1);
        checks++; if (out_fire !== 1'b1 || obs_last !== 1'b1) begin failures++; $display("FAIL last_xfer got=%0b/%0b exp=1/1", out_fire, obs_last); end
        checks++; if (int'(obs_data) !== exp_data) begin failures++; $display("FAIL last_data got=%0d exp=%0d", obs_data, exp_data); end
        drive(1'b0, 16'h0, 1'b1);
        checks++; if (obs_fd !== 1'b1) begin failures++; $display("FAIL last_pulse got=%0b exp=1", obs_fd); end
        drive(1'b0, 16'h0, 1'b1);
        checks++; if (obs_fd !== 1'b0) begin failures++; $display("FAIL last_pulse_end got=%0b exp=0", obs_fd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_frames();
        test_mid_reset();
        test_last_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound so a stuck handshake cannot hang the simulation.
    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
